// File: rtl/divisor_sel.sv
// Divide-select control: two bouncing push-buttons become a saturating 8-bit value
// with single-step on press and auto-repeat on hold.
module divisor_sel #(
  parameter int DEB_CYCLES    = 100000,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int MIN_SEL       = 1,
  parameter int MAX_SEL       = 255,
  parameter int INIT_SEL      = 49
) (
  input  logic       clknexys_i,
  input  logic       rstn_i,
  input  logic       up_i,
  input  logic       down_i,
  output logic [7:0] sel_o,
  output logic       step_o,
  output logic       at_min_o,
  output logic       at_max_o
);

  localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int DW   = $clog2(DEB_CYCLES);
  localparam int TW   = $clog2(TMAX);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);
  localparam logic [7:0]    MIN_V     = 8'(MIN_SEL);
  localparam logic [7:0]    MAX_V     = 8'(MAX_SEL);
  localparam logic [7:0]    INIT_V    = 8'(INIT_SEL);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLD_UP = 3'd1,
    HOLD_DN = 3'd2,
    REP_UP  = 3'd3,
    REP_DN  = 3'd4,
    LOCK    = 3'd5
  } state_t;

  // Bit 0 is the up button, bit 1 the down button throughout.
  logic [1:0]    raw;
  logic [1:0]    sync1_q, sync2_q, deb_q;
  logic [DW-1:0] deb_cnt_q [2];

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          step_up, step_dn;

  logic [7:0]    sel_q, sel_d;
  logic          step_q, step_d;
  logic          at_min_q, at_max_q;

  assign raw = {down_i, up_i};

  always_ff @(posedge clknexys_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int i = 0; i < 2; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        // A change is accepted only after DEB_CYCLES consecutive differing samples.
        if (sync2_q[i] == deb_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DEB_LAST) begin
          deb_q[i]     <= sync2_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clknexys_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    step_up = 1'b0;
    step_dn = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (deb_q[0] && deb_q[1]) begin
          state_d = LOCK;
        end else if (deb_q[0]) begin
          step_up = 1'b1;
          state_d = HOLD_UP;
        end else if (deb_q[1]) begin
          step_dn = 1'b1;
          state_d = HOLD_DN;
        end
      end
      HOLD_UP, REP_UP: begin
        if (!deb_q[0]) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (deb_q[1]) begin
          state_d = LOCK;
          timer_d = '0;
        end else if (timer_q == ((state_q == HOLD_UP) ? HOLD_LAST : REP_LAST)) begin
          step_up = 1'b1;
          timer_d = '0;
          state_d = REP_UP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      HOLD_DN, REP_DN: begin
        if (!deb_q[1]) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (deb_q[0]) begin
          state_d = LOCK;
          timer_d = '0;
        end else if (timer_q == ((state_q == HOLD_DN) ? HOLD_LAST : REP_LAST)) begin
          step_dn = 1'b1;
          timer_d = '0;
          state_d = REP_DN;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      LOCK: begin
        timer_d = '0;
        if (!deb_q[0] && !deb_q[1]) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Saturation is tested before the increment so the value never wraps.
  always_comb begin
    sel_d  = sel_q;
    step_d = 1'b0;
    if (step_up && (sel_q < MAX_V)) begin
      sel_d  = sel_q + 8'd1;
      step_d = 1'b1;
    end else if (step_dn && (sel_q > MIN_V)) begin
      sel_d  = sel_q - 8'd1;
      step_d = 1'b1;
    end
  end

  always_ff @(posedge clknexys_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sel_q    <= INIT_V;
      step_q   <= 1'b0;
      at_min_q <= (INIT_V == MIN_V);
      at_max_q <= (INIT_V == MAX_V);
    end else begin
      sel_q    <= sel_d;
      step_q   <= step_d;
      at_min_q <= (sel_d == MIN_V);
      at_max_q <= (sel_d == MAX_V);
    end
  end

  assign sel_o    = sel_q;
  assign step_o   = step_q;
  assign at_min_o = at_min_q;
  assign at_max_o = at_max_q;

endmodule

// File: tb/tb_divisor_sel.sv
// Directed bench for divisor_sel: debounce latency, glitch rejection, auto-repeat,
// saturation, two-button lock and asynchronous reset.
module tb_divisor_sel;

  logic       clk;
  logic       rstn;
  logic       up;
  logic       down;
  logic [7:0] sel;
  logic       step;
  logic       at_min;
  logic       at_max;

  int n_checks;
  int n_pass;
  int cyc;
  int e0;
  int step_at [$];
  int exp_q   [$];

  divisor_sel #(
    .DEB_CYCLES   (4),
    .HOLD_CYCLES  (20),
    .REPEAT_CYCLES(5),
    .MIN_SEL      (1),
    .MAX_SEL      (10),
    .INIT_SEL     (5)
  ) dut (
    .clknexys_i(clk),
    .rstn_i    (rstn),
    .up_i      (up),
    .down_i    (down),
    .sel_o     (sel),
    .step_o    (step),
    .at_min_o  (at_min),
    .at_max_o  (at_max)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Called at a negedge just before driving a button: the next posedge is offset 0.
  task automatic mark();
    e0 = cyc + 1;
    step_at.delete();
  endtask

  // Records the edge offset (relative to e0) of every step_o pulse.
  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (step === 1'b1) step_at.push_back(cyc - e0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    up   = 1'b0;
    down = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (sel !== 8'd5) $display("FAIL reset_sel got=%0d exp=5", sel); else n_pass++;
    n_checks++; if (step !== 1'b0) $display("FAIL reset_step got=%b exp=0", step); else n_pass++;
    n_checks++; if (at_min !== 1'b0) $display("FAIL reset_at_min got=%b exp=0", at_min); else n_pass++;
    n_checks++; if (at_max !== 1'b0) $display("FAIL reset_at_max got=%b exp=0", at_max); else n_pass++;
  endtask

  task automatic test_clean_press();
    do_reset();
    mark();
    up = 1'b1;
    watch(10);
    up = 1'b0;
    watch(20);
    exp_q = '{6};
    n_checks++;
    if (step_at.size() != exp_q.size())
      $display("FAIL clean_step_count got=%0d exp=%0d", step_at.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < step_at.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (step_at[i] != exp_q[i]) $display("FAIL clean_step_edge[%0d] got=%0d exp=%0d", i, step_at[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++; if (sel !== 8'd6) $display("FAIL clean_sel got=%0d exp=6", sel); else n_pass++;
  endtask

  task automatic test_bounce();
    int lens [15];
    lens = '{1, 2, 3, 1, 2, 1, 3, 3, 1, 2, 3, 1, 2, 2, 3};
    do_reset();
    mark();
    for (int i = 0; i < 15; i++) begin
      up = (i % 2 == 0);
      watch(lens[i]);
    end
    up = 1'b0;
    watch(15);
    n_checks++;
    if (step_at.size() != 0) $display("FAIL bounce_steps got=%0d exp=0", step_at.size()); else n_pass++;
    n_checks++; if (sel !== 8'd5) $display("FAIL bounce_sel got=%0d exp=5", sel); else n_pass++;
  endtask

  task automatic test_hold_up();
    do_reset();
    mark();
    up = 1'b1;
    watch(60);
    n_checks++; if (at_max !== 1'b1) $display("FAIL hold_up_at_max_held got=%b exp=1", at_max); else n_pass++;
    up = 1'b0;
    watch(20);
    exp_q = '{6, 26, 31, 36, 41};
    n_checks++;
    if (step_at.size() != exp_q.size())
      $display("FAIL hold_up_step_count got=%0d exp=%0d", step_at.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < step_at.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (step_at[i] != exp_q[i]) $display("FAIL hold_up_step_edge[%0d] got=%0d exp=%0d", i, step_at[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++; if (sel !== 8'd10) $display("FAIL hold_up_sel got=%0d exp=10", sel); else n_pass++;
    n_checks++; if (at_min !== 1'b0) $display("FAIL hold_up_at_min got=%b exp=0", at_min); else n_pass++;
  endtask

  task automatic test_hold_down();
    do_reset();
    mark();
    down = 1'b1;
    watch(60);
    down = 1'b0;
    watch(20);
    exp_q = '{6, 26, 31, 36};
    n_checks++;
    if (step_at.size() != exp_q.size())
      $display("FAIL hold_dn_step_count got=%0d exp=%0d", step_at.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < step_at.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (step_at[i] != exp_q[i]) $display("FAIL hold_dn_step_edge[%0d] got=%0d exp=%0d", i, step_at[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++; if (sel !== 8'd1) $display("FAIL hold_dn_sel got=%0d exp=1", sel); else n_pass++;
    n_checks++; if (at_min !== 1'b1) $display("FAIL hold_dn_at_min got=%b exp=1", at_min); else n_pass++;
    n_checks++; if (at_max !== 1'b0) $display("FAIL hold_dn_at_max got=%b exp=0", at_max); else n_pass++;
  endtask

  task automatic test_lock();
    do_reset();
    mark();
    up = 1'b1;
    watch(28);
    down = 1'b1;
    watch(22);
    up = 1'b0;
    watch(30);
    down = 1'b0;
    watch(20);
    exp_q = '{6, 26, 31};
    n_checks++;
    if (step_at.size() != exp_q.size())
      $display("FAIL lock_step_count got=%0d exp=%0d", step_at.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < step_at.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (step_at[i] != exp_q[i]) $display("FAIL lock_step_edge[%0d] got=%0d exp=%0d", i, step_at[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++; if (sel !== 8'd8) $display("FAIL lock_sel got=%0d exp=8", sel); else n_pass++;
    mark();
    down = 1'b1;
    watch(10);
    down = 1'b0;
    watch(15);
    n_checks++;
    if (step_at.size() != 1) $display("FAIL unlock_step_count got=%0d exp=1", step_at.size());
    else n_pass++;
    if (step_at.size() == 1) begin
      n_checks++;
      if (step_at[0] != 6) $display("FAIL unlock_step_edge got=%0d exp=6", step_at[0]); else n_pass++;
    end
    n_checks++; if (sel !== 8'd7) $display("FAIL unlock_sel got=%0d exp=7", sel); else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    mark();
    up = 1'b1;
    watch(35);
    n_checks++; if (sel !== 8'd8) $display("FAIL async_pre_sel got=%0d exp=8", sel); else n_pass++;
    rstn = 1'b0;
    #1;
    n_checks++; if (sel !== 8'd5) $display("FAIL async_sel got=%0d exp=5", sel); else n_pass++;
    n_checks++; if (step !== 1'b0) $display("FAIL async_step got=%b exp=0", step); else n_pass++;
    n_checks++; if (at_min !== 1'b0) $display("FAIL async_at_min got=%b exp=0", at_min); else n_pass++;
    n_checks++; if (at_max !== 1'b0) $display("FAIL async_at_max got=%b exp=0", at_max); else n_pass++;
    up = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    step_at.delete();
    watch(15);
    n_checks++;
    if (step_at.size() != 0) $display("FAIL async_post_steps got=%0d exp=0", step_at.size()); else n_pass++;
    n_checks++; if (sel !== 8'd5) $display("FAIL async_post_sel got=%0d exp=5", sel); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    e0       = 0;
    rstn     = 1'b0;
    up       = 1'b0;
    down     = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_hold_up();
    test_hold_down();
    test_lock();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
